// File: rtl/ofm_collector.sv
`default_nettype none
// ============================================================================
// Module   : ofm_collector
// Purpose  : Captures the two tiled output ports of the conv accelerator.
//            Samples arrive banded and tile-interleaved. They are stored in
//            raster order (channel, row, column) and, after a full frame,
//            streamed out over a valid/ready interface.
// Ports    : clk, rst_n (async, active-low)
//            start/cfg_co        - frame start pulse, channel count (cfg_co+1)*8
//            ofm_port0/_v        - sample for row r
//            ofm_port1/_v        - sample for row r+1 (dual beat)
//            rd_valid/rd_ready/rd_data/rd_last - raster-order output stream
//            busy, done, err     - status (err is sticky until start)
// Revision : 1.0 - initial release
// ============================================================================
module ofm_collector #(
  parameter int DATA_W = 25,
  parameter int TI     = 16,
  parameter int TW_N   = 4,
  parameter int BAND_H = 5,
  parameter int BANDS  = 13,
  parameter int MAX_C  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_co,
  input  logic [DATA_W-1:0] ofm_port0,
  input  logic [DATA_W-1:0] ofm_port1,
  input  logic              ofm_port0_v,
  input  logic              ofm_port1_v,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int OFM_W  = TI * TW_N;
  localparam int OFM_H  = BAND_H * BANDS;
  localparam int ROWS   = MAX_C * OFM_H;
  localparam int DEPTH  = ((ROWS + 1) / 2) * OFM_W;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W  = (TI > 1) ? $clog2(TI) : 1;
  localparam int RIB_W  = $clog2(BAND_H + 2);
  localparam int TW_W   = (TW_N > 1) ? $clog2(TW_N) : 1;
  localparam int BAND_W = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int CH_W   = $clog2(MAX_C + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int RDW_W  = (OFM_W > 1) ? $clog2(OFM_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;
  state_t state_q, state_d;

  // Write-side counters
  logic [COL_W-1:0]  col;
  logic [RIB_W-1:0]  rib;
  logic [TW_W-1:0]   tw;
  logic [BAND_W-1:0] band;
  logic [CH_W-1:0]   ch;
  logic [5:0]        cfg_ch;

  // Read-side raster counters; rd_row is the linear (channel*OFM_H + row) index
  logic [ROW_W-1:0]  rd_row;
  logic [RDW_W-1:0]  rd_w;
  logic              fetch_done;

  // Beat decode
  logic        beat, dual, p1_wr, err_set, rib_last, col_end, tw_end, band_end;
  logic        frame_end;
  logic [31:0] rib_sum;
  logic [31:0] colg;
  logic [ROW_W-1:0] row0, row1;
  logic [AW-1:0]    addr0, addr1;

  always_comb begin
    beat     = 1'b0;
    dual     = 1'b0;
    p1_wr    = 1'b0;
    err_set  = 1'b0;
    rib_last = (32'(rib) == BAND_H - 1);
    if (state_q == COLLECT && !start) begin
      if (ofm_port0_v) begin
        beat = 1'b1;
        if (ofm_port1_v) begin
          // A dual beat on the last row of a band would spill into the next
          // band; keep the port0 row only and flag it.
          if (rib_last) begin
            err_set = 1'b1;
          end else begin
            dual  = 1'b1;
            p1_wr = 1'b1;
          end
        end
      end else if (ofm_port1_v) begin
        err_set = 1'b1;
      end
    end
  end

  assign rib_sum  = 32'(rib) + (dual ? 32'd2 : 32'd1);
  assign col_end  = (32'(col) == TI - 1);
  assign tw_end   = (32'(tw) == TW_N - 1);
  assign band_end = (32'(band) == BANDS - 1);
  assign frame_end = beat && col_end && (rib_sum >= BAND_H) && tw_end && band_end &&
                     (32'(ch) + 32'd1 == 32'(cfg_ch));

  // Row-parity banking: rows r and r+1 always land in different banks, so
  // each bank needs only one write port.
  assign colg  = 32'(tw) * TI + 32'(col);
  assign row0  = ROW_W'(32'(ch) * OFM_H + 32'(band) * BAND_H + 32'(rib));
  assign row1  = row0 + 1'b1;
  assign addr0 = AW'(32'(row0 >> 1) * OFM_W + colg);
  assign addr1 = AW'(32'(row1 >> 1) * OFM_W + colg);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic              b0_we, b1_we;
  logic [AW-1:0]     b0_addr, b1_addr;
  logic [DATA_W-1:0] b0_data, b1_data;

  assign b0_we   = row0[0] ? p1_wr : beat;
  assign b1_we   = row0[0] ? beat  : p1_wr;
  assign b0_addr = row0[0] ? addr1 : addr0;
  assign b1_addr = row0[0] ? addr0 : addr1;
  assign b0_data = row0[0] ? ofm_port1 : ofm_port0;
  assign b1_data = row0[0] ? ofm_port0 : ofm_port1;

  always_ff @(posedge clk) begin
    if (b0_we) bank0[b0_addr] <= b0_data;
    if (b1_we) bank1[b1_addr] <= b1_data;
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    if (start) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (frame_end) state_d = DRAIN;
        DRAIN:   if (rd_valid && rd_ready && rd_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Write counters, config latch and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0; rib <= '0; tw <= '0; band <= '0; ch <= '0;
      cfg_ch <= '0;
      err    <= 1'b0;
    end else if (start) begin
      col <= '0; rib <= '0; tw <= '0; band <= '0; ch <= '0;
      cfg_ch <= {3'(cfg_co) + 3'd1, 3'b000};
      err    <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (beat) begin
        if (col_end) begin
          col <= '0;
          if (rib_sum >= BAND_H) begin
            rib <= '0;
            if (tw_end) begin
              tw <= '0;
              if (band_end) begin
                band <= '0;
                ch   <= ch + 1'b1;
              end else begin
                band <= band + 1'b1;
              end
            end else begin
              tw <= tw + 1'b1;
            end
          end else begin
            rib <= RIB_W'(rib_sum);
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Drain: the raster counters run one word ahead of the output register so
  // a new word can be fetched in the same cycle the current one is accepted.
  logic [31:0]   total_rows;
  logic          fetch, fetch_last;
  logic [AW-1:0] rd_addr;

  assign total_rows = 32'(cfg_ch) * OFM_H;
  assign fetch      = (state_q == DRAIN) && !start && !fetch_done && (!rd_valid || rd_ready);
  assign fetch_last = (32'(rd_row) == total_rows - 32'd1) && (32'(rd_w) == OFM_W - 1);
  assign rd_addr    = AW'(32'(rd_row >> 1) * OFM_W + 32'(rd_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      rd_row     <= '0;
      rd_w       <= '0;
      fetch_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state_q == DRAIN) && !start && rd_valid && rd_ready && rd_last;
      if (start) begin
        rd_valid   <= 1'b0;
        rd_last    <= 1'b0;
        rd_row     <= '0;
        rd_w       <= '0;
        fetch_done <= 1'b0;
      end else if (fetch) begin
        rd_data  <= rd_row[0] ? bank1[rd_addr] : bank0[rd_addr];
        rd_valid <= 1'b1;
        rd_last  <= fetch_last;
        if (fetch_last) fetch_done <= 1'b1;
        if (32'(rd_w) == OFM_W - 1) begin
          rd_w   <= '0;
          rd_row <= rd_row + 1'b1;
        end else begin
          rd_w <= rd_w + 1'b1;
        end
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofm_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_collector
// Purpose  : Self-checking bench for ofm_collector. Random samples are sent
//            in banded, tile-interleaved producer order; a raster-indexed
//            reference array predicts every drained word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_collector;
  localparam int DATA_W = 16;
  localparam int TI     = 4;
  localparam int TW_N   = 2;
  localparam int BAND_H = 5;
  localparam int BANDS  = 2;
  localparam int MAX_C  = 32;
  localparam int OFM_W  = TI * TW_N;
  localparam int OFM_H  = BAND_H * BANDS;
  localparam int FRAME  = OFM_W * OFM_H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cfg_co = 2'd0;
  logic [DATA_W-1:0] ofm_port0 = '0;
  logic [DATA_W-1:0] ofm_port1 = '0;
  logic              ofm_port0_v = 1'b0;
  logic              ofm_port1_v = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              err;

  ofm_collector #(
    .DATA_W(DATA_W), .TI(TI), .TW_N(TW_N), .BAND_H(BAND_H), .BANDS(BANDS), .MAX_C(MAX_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_co(cfg_co),
    .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
    .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected frame contents, indexed in raster order (channel, row, column)
  logic [DATA_W-1:0] ref_mem [MAX_C*FRAME];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] co);
    cfg_co = co;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_after_start", 32'(err), 32'd0);
  endtask

  // Producer: walks channels, bands, tiles, rows-in-band and columns in the
  // accelerator's write order. dual_mode sends row pairs wherever a pair fits
  // in the band. inject adds a port1-only beat before beat 10 and an illegal
  // dual beat on the last row of tile 1 of band 0, channel 0.
  task automatic collect(input int nch, input bit dual_mode, input bit inject, input int abort_at);
    int beat;
    bit injected;
    int r;
    int step;
    bit bad_dual;
    int w;
    int row;
    beat = 0;
    injected = 1'b0;
    for (int c = 0; c < nch; c++) begin
      for (int b = 0; b < BANDS; b++) begin
        for (int t = 0; t < TW_N; t++) begin
          r = 0;
          while (r < BAND_H) begin
            step     = (dual_mode && (r + 1 < BAND_H)) ? 2 : 1;
            bad_dual = inject && c == 0 && b == 0 && t == 1 && r == BAND_H - 1;
            for (int x = 0; x < TI; x++) begin
              w   = t * TI + x;
              row = b * BAND_H + r;
              if ($urandom_range(0, 3) == 0) tick;
              if (inject && !injected && beat == 10) begin
                ofm_port1   = DATA_W'($urandom);
                ofm_port1_v = 1'b1;
                tick;
                ofm_port1_v = 1'b0;
                injected    = 1'b1;
                check("err_port1_only", 32'(err), 32'd1);
              end
              ofm_port0   = DATA_W'($urandom);
              ofm_port0_v = 1'b1;
              ref_mem[(c * OFM_H + row) * OFM_W + w] = ofm_port0;
              if (step == 2 || bad_dual) begin
                ofm_port1   = DATA_W'($urandom);
                ofm_port1_v = 1'b1;
                if (step == 2) ref_mem[(c * OFM_H + row + 1) * OFM_W + w] = ofm_port1;
              end
              tick;
              ofm_port0_v = 1'b0;
              ofm_port1_v = 1'b0;
              beat++;
              if (beat == abort_at) return;
            end
            r += step;
          end
        end
      end
    end
    check("busy_in_drain", 32'(busy), 32'd1);
    check("rdv_not_early", 32'(rd_valid), 32'd0);
  endtask

  // Consumer: accepts total words, checking order, rd_last, stall stability
  // and (with ready held high) the absence of bubbles.
  task automatic drain(input int total, input bit rnd_ready, input int stop_after);
    int idx;
    int cyc;
    bit stalled;
    bit seen;
    logic [DATA_W-1:0] hold_d;
    logic hold_l;
    idx = 0; cyc = 0; stalled = 1'b0; seen = 1'b0;
    hold_d = '0; hold_l = 1'b0;
    while (idx < total && cyc < total * 4 + 20) begin
      if (cyc == 1) check("first_valid", 32'(rd_valid), 32'd1);
      if (stalled) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_data", 32'(rd_data), 32'(hold_d));
        check("stall_last", 32'(rd_last), 32'(hold_l));
      end
      if (!rnd_ready && seen) check("no_bubble", 32'(rd_valid), 32'd1);
      rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (rd_valid) begin
        seen = 1'b1;
        if (rd_ready) begin
          check("data", 32'(rd_data), 32'(ref_mem[idx]));
          check("last", 32'(rd_last), (idx == total - 1) ? 32'd1 : 32'd0);
          idx++;
        end else begin
          stalled = 1'b1;
          hold_d  = rd_data;
          hold_l  = rd_last;
        end
      end
      if (stop_after >= 0 && idx == stop_after) return;
      tick;
      cyc++;
    end
    rd_ready = 1'b0;
    check("word_count", 32'(idx), 32'(total));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    tick;
    check("done_once", 32'(done), 32'd0);
    check("rdv_idle", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick;
    check("idle_busy", 32'(busy), 32'd0);

    // 8 channels, single beats, ready held high
    pulse_start(2'd0);
    collect(8, 1'b0, 1'b0, -1);
    check("err_single", 32'(err), 32'd0);
    drain(8 * FRAME, 1'b0, -1);

    // 16 channels, dual beats, random backpressure
    pulse_start(2'd1);
    collect(16, 1'b1, 1'b0, -1);
    check("err_dual", 32'(err), 32'd0);
    drain(16 * FRAME, 1'b1, -1);

    // Protocol errors: port1 alone and dual beat on the last band row
    pulse_start(2'd0);
    collect(8, 1'b0, 1'b1, -1);
    check("err_protocol", 32'(err), 32'd1);
    drain(8 * FRAME, 1'b1, -1);
    check("err_sticky", 32'(err), 32'd1);

    // Restart mid-COLLECT after an error
    pulse_start(2'd0);
    collect(8, 1'b0, 1'b1, 100);
    check("err_before_restart", 32'(err), 32'd1);
    pulse_start(2'd0);
    collect(8, 1'b0, 1'b0, -1);
    check("err_restart", 32'(err), 32'd0);
    drain(8 * FRAME, 1'b0, -1);

    // Reset during DRAIN
    pulse_start(2'd0);
    collect(8, 1'b0, 1'b0, -1);
    drain(8 * FRAME, 1'b1, 50);
    rst_n = 1'b0;
    #1;
    check("rstd_rd_valid", 32'(rd_valid), 32'd0);
    check("rstd_busy", 32'(busy), 32'd0);
    check("rstd_rd_data", 32'(rd_data), 32'd0);
    check("rstd_rd_last", 32'(rd_last), 32'd0);
    rd_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    ofm_port0_v = 1'b1;
    ofm_port1_v = 1'b1;
    tick;
    ofm_port0_v = 1'b0;
    ofm_port1_v = 1'b0;
    tick;
    check("idle_err", 32'(err), 32'd0);
    check("idle_busy2", 32'(busy), 32'd0);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Full-capacity configuration
    pulse_start(2'd3);
    collect(32, 1'b0, 1'b0, -1);
    check("err_sweep", 32'(err), 32'd0);
    drain(32 * FRAME, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
